// File: rtl/vram_host_arbiter_pkg.sv
// Shared types and constants for the VRAM host-port arbiter.
//   arb_owner_e       : which requester owns an access (CPU or DMA)
//   vram_req_t        : one host-port request bundle at the default bus widths
//   rdtag_t           : one stage of the read-return tag pipe
//   VRAM_ARB_STARVE_W : width of the DMA starvation counter
package vram_host_arbiter_pkg;

    localparam int VRAM_ARB_STARVE_W = 8;
    localparam int VRAM_ARB_ADDR_W   = 32;
    localparam int VRAM_ARB_DATA_W   = 32;

    typedef enum logic {
        ARB_CPU = 1'b0,
        ARB_DMA = 1'b1
    } arb_owner_e;

    typedef struct packed {
        logic                       we;
        logic [VRAM_ARB_ADDR_W-1:0] addr;
        logic [VRAM_ARB_DATA_W-1:0] wdata;
    } vram_req_t;

    typedef struct packed {
        logic       valid;
        arb_owner_e owner;
    } rdtag_t;

    // Saturating increment of the starvation counter: sticks at the limit.
    function automatic logic [VRAM_ARB_STARVE_W-1:0] starve_next(
        input logic [VRAM_ARB_STARVE_W-1:0] cnt,
        input logic [VRAM_ARB_STARVE_W-1:0] limit
    );
        if (cnt == limit) begin
            return cnt;
        end else begin
            return cnt + 8'd1;
        end
    endfunction

endpackage

// File: rtl/vram_host_arbiter_if.sv
// Bus bundle between the two requesters (CPU, DMA), the arbiter and the
// VRAM host port.
//   slave  : arbiter view (takes requests and mem_dout, drives grants,
//            read returns and the mem_* strobe)
//   master : environment view (requesters plus VRAM)
interface vram_host_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;

    logic              dma_req;
    logic              dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wdata;
    logic              dma_gnt;
    logic              dma_rvalid;
    logic [DATA_W-1:0] dma_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output dma_gnt, dma_rvalid, dma_rdata,
        output mem_en, mem_we, mem_addr, mem_din,
        input  mem_dout
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  dma_gnt, dma_rvalid, dma_rdata,
        input  mem_en, mem_we, mem_addr, mem_din,
        output mem_dout
    );

endinterface

// File: rtl/vram_host_arbiter_rdtag_pipe.sv
// Read-return tag pipe: a shift register of {valid, owner} entries.
// A tag pushed in cycle N appears on the output in cycle N+DEPTH.
//   clk, rst          : clock, asynchronous active-high clear
//   i_valid, i_owner  : tag entering at grant time
//   o_valid, o_owner  : tag leaving the last stage
module vram_arb_rdtag_pipe
    import vram_host_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_valid,
    input  arb_owner_e i_owner,
    output logic       o_valid,
    output arb_owner_e o_owner
);

    rdtag_t [DEPTH-1:0] r_stage;

    // Shift tags one stage per cycle; reset drops every tag in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stage <= '0;
        end else begin
            r_stage[0] <= '{valid: i_valid, owner: i_owner};
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_valid = r_stage[DEPTH-1].valid;
    assign o_owner = r_stage[DEPTH-1].owner;

endmodule

// File: rtl/vram_host_arbiter.sv
// Shares the single VRAM host port between the CPU bus and the VRAM DMA
// engine. Fixed CPU priority; a starvation counter forces a DMA grant after
// STARVE_MAX waiting cycles. One access per cycle, registered onto mem_*.
// Read data is routed back to its issuer through a tag pipe of depth
// RD_LAT+1.
//   clk, rst : system clock, asynchronous active-high reset
//   vblank   : vertical-blank flag, only used with VRAM_ARB_VBLANK_GATE_EN
//   bus      : requester handshakes, read returns and the VRAM host port
// Optional feature: define VRAM_ARB_VBLANK_GATE_EN to only grant DMA while
// vblank=1 (the starvation counter also pauses while vblank=0).
module vram_host_arbiter
    import vram_host_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 vblank,
    vram_host_arbiter_if.slave   bus
);

    localparam logic [VRAM_ARB_STARVE_W-1:0] STARVE_LIM = VRAM_ARB_STARVE_W'(STARVE_MAX);

    logic                         w_dma_ok;
    logic                         w_cpu_gnt;
    logic                         w_dma_gnt;
    logic                         w_win_we;
    logic [ADDR_W-1:0]            w_win_addr;
    logic [DATA_W-1:0]            w_win_wdata;
    logic                         w_tag_in_valid;
    arb_owner_e                   w_tag_in_owner;
    logic                         w_tag_valid;
    arb_owner_e                   w_tag_owner;
    logic                         w_cpu_rvalid;
    logic                         w_dma_rvalid;

    logic [VRAM_ARB_STARVE_W-1:0] r_starve_cnt;
    logic                         r_mem_en;
    logic                         r_mem_we;
    logic [ADDR_W-1:0]            r_mem_addr;
    logic [DATA_W-1:0]            r_mem_din;
    logic [DATA_W-1:0]            r_cpu_rdata;
    logic [DATA_W-1:0]            r_dma_rdata;

`ifdef VRAM_ARB_VBLANK_GATE_EN
    assign w_dma_ok = vblank;
`else
    // vblank is ignored here; OR-ing keeps the port referenced.
    assign w_dma_ok = vblank | 1'b1;
`endif

    // Arbitration: CPU has priority unless DMA has starved to the limit.
    always_comb begin
        w_cpu_gnt = 1'b0;
        w_dma_gnt = 1'b0;
        if (rst) begin
            w_cpu_gnt = 1'b0;
            w_dma_gnt = 1'b0;
        end else if (bus.dma_req && w_dma_ok &&
                     (!bus.cpu_req || (r_starve_cnt == STARVE_LIM))) begin
            w_dma_gnt = 1'b1;
        end else if (bus.cpu_req) begin
            w_cpu_gnt = 1'b1;
        end else begin
            w_cpu_gnt = 1'b0;
            w_dma_gnt = 1'b0;
        end
    end

    // Select the winner's request and the tag for a read return.
    always_comb begin
        w_win_we       = bus.cpu_we;
        w_win_addr     = bus.cpu_addr;
        w_win_wdata    = bus.cpu_wdata;
        w_tag_in_owner = ARB_CPU;
        if (w_dma_gnt) begin
            w_win_we       = bus.dma_we;
            w_win_addr     = bus.dma_addr;
            w_win_wdata    = bus.dma_wdata;
            w_tag_in_owner = ARB_DMA;
        end else begin
            w_win_we       = bus.cpu_we;
            w_win_addr     = bus.cpu_addr;
            w_win_wdata    = bus.cpu_wdata;
            w_tag_in_owner = ARB_CPU;
        end
        w_tag_in_valid = (w_cpu_gnt || w_dma_gnt) && !w_win_we;
    end

    // Starvation counter: counts eligible DMA cycles lost to the CPU.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve_cnt <= 8'd0;
        end else if (!bus.dma_req || w_dma_gnt) begin
            r_starve_cnt <= 8'd0;
        end else if (w_dma_ok) begin
            r_starve_cnt <= starve_next(r_starve_cnt, STARVE_LIM);
        end else begin
            r_starve_cnt <= r_starve_cnt;
        end
    end

    // Host-port issue register; address/data hold when nothing is granted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem_en   <= 1'b0;
            r_mem_we   <= 1'b0;
            r_mem_addr <= '0;
            r_mem_din  <= '0;
        end else if (w_cpu_gnt || w_dma_gnt) begin
            r_mem_en   <= 1'b1;
            r_mem_we   <= w_win_we;
            r_mem_addr <= w_win_addr;
            r_mem_din  <= w_win_wdata;
        end else begin
            r_mem_en   <= 1'b0;
            r_mem_we   <= 1'b0;
        end
    end

    vram_arb_rdtag_pipe #(
        .DEPTH (RD_LAT + 1)
    ) u_rdtag_pipe (
        .clk     (clk),
        .rst     (rst),
        .i_valid (w_tag_in_valid),
        .i_owner (w_tag_in_owner),
        .o_valid (w_tag_valid),
        .o_owner (w_tag_owner)
    );

    assign w_cpu_rvalid = w_tag_valid && (w_tag_owner == ARB_CPU);
    assign w_dma_rvalid = w_tag_valid && (w_tag_owner == ARB_DMA);

    // Remember the last returned word per requester so rdata holds between pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cpu_rdata <= '0;
            r_dma_rdata <= '0;
        end else begin
            r_cpu_rdata <= w_cpu_rvalid ? bus.mem_dout : r_cpu_rdata;
            r_dma_rdata <= w_dma_rvalid ? bus.mem_dout : r_dma_rdata;
        end
    end

    // mem_dout is only valid in the return cycle itself, so it is passed
    // straight through then and the held copy is shown otherwise.
    assign bus.cpu_gnt    = w_cpu_gnt;
    assign bus.dma_gnt    = w_dma_gnt;
    assign bus.cpu_rvalid = w_cpu_rvalid;
    assign bus.dma_rvalid = w_dma_rvalid;
    assign bus.cpu_rdata  = w_cpu_rvalid ? bus.mem_dout : r_cpu_rdata;
    assign bus.dma_rdata  = w_dma_rvalid ? bus.mem_dout : r_dma_rdata;
    assign bus.mem_en     = r_mem_en;
    assign bus.mem_we     = r_mem_we;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_din    = r_mem_din;

endmodule

// File: tb/tb_vram_host_arbiter.sv
// Self-checking bench for vram_host_arbiter: directed vectors, a per-cycle
// reference model of the arbitration/issue/return rules, and literal checks.
module tb_vram_host_arbiter;
    import vram_host_arbiter_pkg::*;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int RDL  = 1;
    localparam int SMAX = 8;

    logic clk = 1'b0;
    logic rst;
    logic vblank;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    vram_host_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    vram_host_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .RD_LAT(RDL), .STARVE_MAX(SMAX)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .vblank (vblank),
        .bus    (bus)
    );

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] init_val(input int idx);
        return {16'hC0DE, 8'h00, 8'(idx)};
    endfunction

    // ---------------- VRAM environment (driven from the mem_* pins) -----
    logic [DW-1:0] env_mem [256];
    logic [DW-1:0] dout_pipe [RDL];
    initial for (int i = 0; i < 256; i++) env_mem[i] = init_val(i);

    always @(posedge clk) begin
        if (bus.mem_en && bus.mem_we) env_mem[bus.mem_addr[9:2]] <= bus.mem_din;
        dout_pipe[0] <= (bus.mem_en && !bus.mem_we) ? env_mem[bus.mem_addr[9:2]]
                                                    : (32'hBAD0_0000 ^ DW'(cyc));
        for (int i = 1; i < RDL; i++) dout_pipe[i] <= dout_pipe[i-1];
    end
    assign bus.mem_dout = dout_pipe[RDL-1];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- reference model + per-cycle compare ---------------
    typedef struct {
        int            due;
        bit            is_dma;
        logic [DW-1:0] data;
    } rd_t;

    rd_t           rq[$];
    int            m_wait = 0;
    bit            e_en = 1'b0, e_we = 1'b0;
    logic [AW-1:0] e_addr = '0;
    logic [DW-1:0] e_din = '0, e_crd = '0, e_drd = '0;
    logic [DW-1:0] shadow [256];
    initial for (int i = 0; i < 256; i++) shadow[i] = init_val(i);

    always @(negedge clk) begin
        bit g_c, g_d, dok, rv_c, rv_d;
        if (rst) begin
            chk("rst_cpu_gnt", bus.cpu_gnt, 0);      chk("rst_dma_gnt", bus.dma_gnt, 0);
            chk("rst_mem_en", bus.mem_en, 0);        chk("rst_mem_we", bus.mem_we, 0);
            chk("rst_mem_addr", bus.mem_addr, 0);    chk("rst_mem_din", bus.mem_din, 0);
            chk("rst_cpu_rvalid", bus.cpu_rvalid, 0); chk("rst_dma_rvalid", bus.dma_rvalid, 0);
            chk("rst_cpu_rdata", bus.cpu_rdata, 0);  chk("rst_dma_rdata", bus.dma_rdata, 0);
            m_wait = 0; e_en = 0; e_we = 0; e_addr = '0; e_din = '0;
            e_crd = '0; e_drd = '0; rq.delete();
        end else begin
`ifdef VRAM_ARB_VBLANK_GATE_EN
            dok = vblank;
`else
            dok = 1'b1;
`endif
            g_d = bus.dma_req && dok && (!bus.cpu_req || m_wait == SMAX);
            g_c = bus.cpu_req && !g_d;
            rv_c = 1'b0; rv_d = 1'b0;
            if (rq.size() > 0 && rq[0].due == cyc) begin
                if (rq[0].is_dma) begin rv_d = 1'b1; e_drd = rq[0].data; end
                else              begin rv_c = 1'b1; e_crd = rq[0].data; end
                void'(rq.pop_front());
            end
            chk("cpu_gnt", bus.cpu_gnt, g_c);         chk("dma_gnt", bus.dma_gnt, g_d);
            chk("mem_en", bus.mem_en, e_en);          chk("mem_we", bus.mem_we, e_we);
            chk("mem_addr", bus.mem_addr, e_addr);    chk("mem_din", bus.mem_din, e_din);
            chk("cpu_rvalid", bus.cpu_rvalid, rv_c);  chk("dma_rvalid", bus.dma_rvalid, rv_d);
            chk("cpu_rdata", bus.cpu_rdata, e_crd);   chk("dma_rdata", bus.dma_rdata, e_drd);
            // advance the model to the next cycle
            if (!bus.dma_req || g_d) m_wait = 0;
            else if (dok && m_wait < SMAX) m_wait++;
            e_en = g_c || g_d;
            if (g_c || g_d) begin
                e_we   = g_d ? bus.dma_we : bus.cpu_we;
                e_addr = g_d ? bus.dma_addr : bus.cpu_addr;
                e_din  = g_d ? bus.dma_wdata : bus.cpu_wdata;
                if (e_we) shadow[e_addr[9:2]] = e_din;
                else rq.push_back('{due: cyc + 1 + RDL, is_dma: g_d, data: shadow[e_addr[9:2]]});
            end else begin
                e_we = 1'b0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic next();
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        bus.cpu_req = 1'b0; bus.dma_req = 1'b0;
        repeat (n) next();
    endtask

    initial begin
        rst = 1'b1; vblank = 1'b0;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.dma_req = 1'b0; bus.dma_we = 1'b0; bus.dma_addr = '0; bus.dma_wdata = '0;
        // T1: reset with cpu_req held, first grant right after release
        repeat (3) next();
        rst = 1'b0;
        @(negedge clk); chk("t1_first_cpu_gnt", bus.cpu_gnt, 1);
        next(); idle(4);

        // T2: single CPU read of 0x10
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h10;
        @(negedge clk); chk("t2_cpu_gnt", bus.cpu_gnt, 1);
        next(); bus.cpu_req = 1'b0;
        @(negedge clk); chk("t2_mem_en", bus.mem_en, 1); chk("t2_mem_addr", bus.mem_addr, 32'h10);
        next();
        @(negedge clk); chk("t2_cpu_rvalid", bus.cpu_rvalid, 1);
        chk("t2_cpu_rdata", bus.cpu_rdata, 32'hC0DE_0004); chk("t2_dma_rvalid", bus.dma_rvalid, 0);
        next(); idle(3);

        // T3: contention, CPU writes 0x40 while DMA reads 0x40
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 32'h40;
        bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 32'h40;
        for (int k = 0; k < 20; k++) begin
            bus.cpu_wdata = 32'h1000 + 32'(k);
            @(negedge clk);
            chk("t3_dma_gnt", bus.dma_gnt, (k == 8 || k == 17));
            if (k == 10) begin
                chk("t3_dma_rvalid", bus.dma_rvalid, 1);
                chk("t3_dma_rdata", bus.dma_rdata, 32'h0000_1007);
            end
            next();
        end
        idle(4);

        // DMA drops its request before ever being granted, then writes and reads back
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h50;
        bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_addr = 32'h54; bus.dma_wdata = 32'hDEAD_0054;
        repeat (3) next();
        bus.dma_req = 1'b0; repeat (2) next();
        bus.cpu_req = 1'b0;
`ifndef VRAM_ARB_VBLANK_GATE_EN
        vblank = 1'b0;
        bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_addr = 32'h60; bus.dma_wdata = 32'hDA7A_0060;
        @(negedge clk); chk("vblank_ignored_dma_gnt", bus.dma_gnt, 1);
        next(); bus.dma_we = 1'b0;
        next(); bus.dma_req = 1'b0;
        next();
        @(negedge clk); chk("dma_readback", bus.dma_rdata, 32'hDA7A_0060);
`endif
        idle(4);

        // T4: interleaved reads cpu 0x20, dma 0x24, cpu 0x28
        for (int j = 0; j < 6; j++) begin
            bus.cpu_req = (j == 0 || j == 2); bus.cpu_we = 1'b0;
            bus.cpu_addr = (j == 0) ? 32'h20 : 32'h28;
            bus.dma_req = (j == 1); bus.dma_we = 1'b0; bus.dma_addr = 32'h24;
            vblank = 1'b1;
            @(negedge clk);
            chk("t4_cpu_rvalid", bus.cpu_rvalid, (j == 2 || j == 4));
            chk("t4_dma_rvalid", bus.dma_rvalid, (j == 3));
            if (j == 2) chk("t4_cpu_rdata0", bus.cpu_rdata, 32'hC0DE_0008);
            if (j == 3) chk("t4_dma_rdata", bus.dma_rdata, 32'hC0DE_0009);
            if (j == 4) chk("t4_cpu_rdata1", bus.cpu_rdata, 32'hC0DE_000A);
            next();
        end
        vblank = 1'b0;
        idle(3);

        // T5: reset asserted in the cycle after the read's mem_en
        for (int j = 0; j < 9; j++) begin
            bus.cpu_req = (j == 0); bus.cpu_we = 1'b0; bus.cpu_addr = 32'h30;
            rst = (j == 2 || j == 3);
            @(negedge clk);
            if (j == 1) chk("t5_mem_en", bus.mem_en, 1);
            if (j >= 2) chk("t5_no_cpu_rvalid", bus.cpu_rvalid, 0);
            next();
        end

`ifdef VRAM_ARB_VBLANK_GATE_EN
        // T6: DMA gated by vblank
        bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 32'h70; vblank = 1'b0;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk); chk("t6_gated_dma_gnt", bus.dma_gnt, 0);
            next();
        end
        vblank = 1'b1;
        @(negedge clk); chk("t6_vblank_dma_gnt", bus.dma_gnt, 1);
        next();
        // starvation count must restart from zero: 8 CPU grants before DMA
        bus.cpu_req = 1'b1;
        for (int j = 0; j < 9; j++) begin
            @(negedge clk); chk("t6_starve_dma_gnt", bus.dma_gnt, (j == 8));
            next();
        end
        vblank = 1'b0;
`endif
        idle(5);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
